// File: rtl/hs_rx_multi.sv
// Multi-channel req/ack receiver: per-channel request synchronisers, round-robin
// arbitration into a shared FIFO, drained through a valid/ready port tagged by channel.
module hs_rx_multi #(
    parameter int unsigned N           = 8,
    parameter int unsigned CH          = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned ACK_MODE    = 1
) (
    input  logic                                   clkb,
    input  logic                                   rst,
    input  logic [CH-1:0]                          data_req,
    input  logic [CH*N-1:0]                        data,
    output logic [CH-1:0]                          data_ack,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [N-1:0]                           out_data,
    output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] out_ch,
    output logic [$clog2(DEPTH+1)-1:0]             fifo_count
);

    localparam int unsigned CW   = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, PEND, ACKW} ch_state_e;

    ch_state_e       st [CH];
    logic [CH-1:0]   sync_q [SYNC_STAGES];
    logic [CH-1:0]   req_s;
    logic [CH-1:0]   req_p;
    logic [CH-1:0]   rise;

    logic [CW-1:0]   rr_ptr;
    logic            gnt_vld;
    logic [CW-1:0]   gnt_idx;
    logic [CH-1:0]   gnt_oh;
    logic [N-1:0]    wr_data;

    logic [N-1:0]    mem_data [DEPTH];
    logic [CW-1:0]   mem_ch   [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            pop;
    logic [CNTW-1:0] cnt_nxt;

    // Channel index 'off' positions after 'base', wrapping at CH.
    function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= CH) s = s - CH;
        return CW'(s);
    endfunction

    assign req_s = sync_q[SYNC_STAGES-1];
    assign rise  = req_s & ~req_p;
    assign pop   = out_valid & out_ready;

    assign out_data = out_valid ? mem_data[rd_ptr] : '0;
    assign out_ch   = out_valid ? mem_ch[rd_ptr]   : '0;

    // Round-robin search over pending channels, blocked only by the registered count.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        gnt_oh  = '0;
        wr_data = '0;
        if (fifo_count < CNTW'(DEPTH)) begin
            for (int unsigned i = 0; i < CH; i++) begin
                if (!gnt_vld && st[rr_idx(rr_ptr, i)] == PEND) begin
                    gnt_vld = 1'b1;
                    gnt_idx = rr_idx(rr_ptr, i);
                end
            end
        end
        for (int unsigned c = 0; c < CH; c++) begin
            if (gnt_vld && gnt_idx == CW'(c)) begin
                gnt_oh[c] = 1'b1;
                wr_data   = data[c*N +: N];
            end
        end
    end

    always_comb begin
        cnt_nxt = fifo_count;
        case ({gnt_vld, pop})
            2'b10:   cnt_nxt = fifo_count + CNTW'(1);
            2'b01:   cnt_nxt = fifo_count - CNTW'(1);
            default: cnt_nxt = fifo_count;
        endcase
    end

    always_ff @(posedge clkb) begin
        if (gnt_vld) begin
            mem_data[wr_ptr] <= wr_data;
            mem_ch[wr_ptr]   <= gnt_idx;
        end
    end

    always_ff @(posedge clkb) begin
        if (rst) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            for (int unsigned c = 0; c < CH; c++) st[c] <= IDLE;
            req_p      <= '0;
            data_ack   <= '0;
            rr_ptr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            out_valid  <= 1'b0;
        end else begin
            sync_q[0] <= data_req;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            req_p <= req_s;

            for (int unsigned c = 0; c < CH; c++) begin
                case (st[c])
                    IDLE:    if (rise[c]) st[c] <= PEND;
                    PEND:    if (gnt_oh[c]) st[c] <= (ACK_MODE == 0) ? IDLE : ACKW;
                    ACKW:    if (!req_s[c]) st[c] <= IDLE;
                    default: st[c] <= IDLE;
                endcase
                // Pulse mode acks only the grant edge; 4-phase holds while the request stays up.
                data_ack[c] <= (ACK_MODE == 0) ? gnt_oh[c]
                                               : (gnt_oh[c] | ((st[c] == ACKW) & req_s[c]));
            end

            if (gnt_vld) begin
                wr_ptr <= wr_ptr + AW'(1);
                rr_ptr <= rr_idx(gnt_idx, 1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= cnt_nxt;
            out_valid  <= (cnt_nxt != '0);
        end
    end

endmodule

// File: tb/tb_hs_rx_multi.sv
// Scoreboard bench for hs_rx_multi: pulse-ack and 4-phase-ack instances share
// stimulus; a cycle-level reference model predicts acks, count and FIFO contents.
module tb_hs_rx_multi;

    localparam int unsigned N     = 8;
    localparam int unsigned CH    = 2;
    localparam int unsigned S     = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 1;
    localparam int unsigned CNTW  = 3;

    localparam int IDLE_W = 0;   // not requesting
    localparam int WAIT_W = 1;   // request seen, waiting for a grant
    localparam int HOLD_W = 2;   // granted, ack held until request drops

    logic clkb = 1'b0;
    always #5 clkb = ~clkb;

    logic              rst;
    logic [CH-1:0]     data_req;
    logic [CH*N-1:0]   data;
    logic              out_ready;

    logic [CH-1:0]     ack_m [2];
    logic              ov_m  [2];
    logic [N-1:0]      od_m  [2];
    logic [CW-1:0]     oc_m  [2];
    logic [CNTW-1:0]   fc_m  [2];

    hs_rx_multi #(.N(N), .CH(CH), .SYNC_STAGES(S), .DEPTH(DEPTH), .ACK_MODE(0)) u_dut0 (
        .clkb(clkb), .rst(rst), .data_req(data_req), .data(data), .data_ack(ack_m[0]),
        .out_valid(ov_m[0]), .out_ready(out_ready), .out_data(od_m[0]), .out_ch(oc_m[0]),
        .fifo_count(fc_m[0])
    );

    hs_rx_multi #(.N(N), .CH(CH), .SYNC_STAGES(S), .DEPTH(DEPTH), .ACK_MODE(1)) u_dut1 (
        .clkb(clkb), .rst(rst), .data_req(data_req), .data(data), .data_ack(ack_m[1]),
        .out_valid(ov_m[1]), .out_ready(out_ready), .out_data(od_m[1]), .out_ch(oc_m[1]),
        .fifo_count(fc_m[1])
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit armed    = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [CH-1:0]      hist [S+1];     // hist[k] = data_req sampled k+1 edges ago
    int                 phase [2][CH];
    int                 occ   [2];
    int                 next_rr [2];
    logic [CH-1:0]      mack  [2];
    logic [CW+N-1:0]    exp_q0 [$];
    logic [CW+N-1:0]    exp_q1 [$];

    initial begin
        for (int k = 0; k <= S; k++) hist[k] = '0;
        for (int m = 0; m < 2; m++) begin
            occ[m] = 0; next_rr[m] = 0; mack[m] = '0;
            for (int c = 0; c < CH; c++) phase[m][c] = IDLE_W;
        end
    end

    always @(posedge clkb) begin : model
        logic [CH-1:0]   seen, seen_prev, new_ack;
        logic [CW+N-1:0] ent;
        int              g, c;
        bit              popped;
        seen      = hist[S-1];
        seen_prev = hist[S];
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                occ[m] = 0; next_rr[m] = 0; mack[m] = '0;
                for (int k = 0; k < CH; k++) phase[m][k] = IDLE_W;
            end else begin
                popped = (occ[m] != 0) && out_ready;
                g = -1;
                if (occ[m] < DEPTH) begin
                    for (int i = 0; i < CH; i++) begin
                        c = (next_rr[m] + i) % CH;
                        if (g < 0 && phase[m][c] == WAIT_W) g = c;
                    end
                end
                new_ack = '0;
                for (int k = 0; k < CH; k++) begin
                    if (phase[m][k] == IDLE_W) begin
                        if (seen[k] && !seen_prev[k]) phase[m][k] = WAIT_W;
                    end else if (phase[m][k] == WAIT_W) begin
                        if (k == g) begin
                            phase[m][k] = (m == 0) ? IDLE_W : HOLD_W;
                            new_ack[k]  = 1'b1;
                        end
                    end else begin
                        if (seen[k]) new_ack[k] = 1'b1;
                        else         phase[m][k] = IDLE_W;
                    end
                end
                if (g >= 0) begin
                    ent = {CW'(g), data[g*N +: N]};
                    if (m == 0) exp_q0.push_back(ent);
                    else        exp_q1.push_back(ent);
                    next_rr[m] = (g + 1) % CH;
                    occ[m]++;
                end
                if (popped) occ[m]--;
                mack[m] = new_ack;
            end
        end
        if (rst) begin
            for (int k = 0; k <= S; k++) hist[k] = '0;
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            for (int k = S; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = data_req;
        end
    end

    // Monitor: compares outputs against the model, pops the scoreboard on each transfer.
    always @(negedge clkb) begin : monitor
        logic [CW+N-1:0] e;
        int              qsz;
        if (armed) begin
            for (int m = 0; m < 2; m++) begin
                check($sformatf("fifo_count[%0d]", m), 32'(fc_m[m]), 32'(occ[m]));
                check($sformatf("out_valid[%0d]", m), 32'(ov_m[m]), 32'(occ[m] != 0));
                check($sformatf("data_ack[%0d]", m), 32'(ack_m[m]), 32'(mack[m]));
                if (ov_m[m] === 1'b1 && out_ready === 1'b1) begin
                    qsz = (m == 0) ? exp_q0.size() : exp_q1.size();
                    if (qsz == 0) begin
                        check($sformatf("scoreboard_empty[%0d]", m), 32'(ov_m[m]), 32'(0));
                    end else begin
                        e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check($sformatf("out_data[%0d]", m), 32'(od_m[m]), 32'(e[N-1:0]));
                        check($sformatf("out_ch[%0d]", m), 32'(oc_m[m]), 32'(e[CW+N-1:N]));
                    end
                end
            end
        end
    end

    task automatic drive_edge();
        @(posedge clkb);
        #2;
    endtask

    task automatic send(input int c, input logic [N-1:0] v, input int hold, input int gap);
        drive_edge();
        data[c*N +: N] = v;
        data_req[c]    = 1'b1;
        repeat (hold) @(posedge clkb);
        #2;
        data_req[c] = 1'b0;
        repeat (gap) @(posedge clkb);
    endtask

    initial begin
        rst       = 1'b1;
        data_req  = '0;
        data      = '0;
        out_ready = 1'b0;
        @(posedge clkb);
        #1 armed = 1'b1;
        drive_edge();
        rst = 1'b0;

        // Reset values
        @(negedge clkb);
        check("rst_out_data", 32'(od_m[1]), 32'h0);
        check("rst_out_ch", 32'(oc_m[1]), 32'h0);
        check("rst_out_valid", 32'(ov_m[1]), 32'h0);
        check("rst_fifo_count", 32'(fc_m[1]), 32'h0);
        check("rst_data_ack", 32'(ack_m[1]), 32'h0);

        // Single transfer, request raised before edge 0
        drive_edge();
        data[7:0]   = 8'hA5;
        data_req[0] = 1'b1;
        out_ready   = 1'b1;
        repeat (3) @(posedge clkb);
        @(negedge clkb);
        check("lat_ack_before_e3", 32'(ack_m[1][0]), 32'h0);
        @(posedge clkb);
        @(negedge clkb);
        check("lat_ack_e3", 32'(ack_m[1][0]), 32'h1);
        check("lat_pulse_e3", 32'(ack_m[0][0]), 32'h1);
        check("lat_valid_e3", 32'(ov_m[1]), 32'h1);
        check("lat_data_e3", 32'(od_m[1]), 32'hA5);
        check("lat_ch_e3", 32'(oc_m[1]), 32'h0);
        @(posedge clkb);
        @(negedge clkb);
        check("pulse_one_cycle", 32'(ack_m[0][0]), 32'h0);
        check("level_ack_held", 32'(ack_m[1][0]), 32'h1);
        drive_edge();
        data_req[0] = 1'b0;
        repeat (2) @(posedge clkb);
        @(negedge clkb);
        check("drop_ack_k1", 32'(ack_m[1][0]), 32'h1);
        @(posedge clkb);
        @(negedge clkb);
        check("drop_ack_k2", 32'(ack_m[1][0]), 32'h0);
        repeat (3) @(posedge clkb);

        // Simultaneous requests, then ch0 alone, then both again to exercise round-robin
        drive_edge();
        data     = {8'h22, 8'h11};
        data_req = 2'b11;
        repeat (8) @(posedge clkb);
        #2 data_req = 2'b00;
        repeat (6) @(posedge clkb);
        send(0, 8'h33, 7, 6);
        drive_edge();
        data     = {8'h44, 8'h55};
        data_req = 2'b11;
        repeat (8) @(posedge clkb);
        #2 data_req = 2'b00;
        repeat (6) @(posedge clkb);

        // Backpressure: four words fill the FIFO, the fifth waits
        drive_edge();
        out_ready = 1'b0;
        send(0, 8'h31, 6, 5);
        send(1, 8'h32, 6, 5);
        send(0, 8'h33, 6, 5);
        send(1, 8'h34, 6, 5);
        drive_edge();
        data[7:0]   = 8'h35;
        data_req[0] = 1'b1;
        repeat (10) @(posedge clkb);
        @(negedge clkb);
        check("bp_full_count", 32'(fc_m[1]), 32'h4);
        check("bp_stall_ack", 32'(ack_m[1][0]), 32'h0);
        check("bp_full_count_pulse", 32'(fc_m[0]), 32'h4);
        drive_edge();
        out_ready = 1'b1;
        drive_edge();
        out_ready = 1'b0;
        @(posedge clkb);
        @(negedge clkb);
        check("bp_refill_count", 32'(fc_m[1]), 32'h4);
        check("bp_refill_ack", 32'(ack_m[1][0]), 32'h1);
        drive_edge();
        data_req[0] = 1'b0;
        out_ready   = 1'b1;
        repeat (12) @(posedge clkb);

        // Random traffic with random backpressure
        for (int cyc = 0; cyc < 800; cyc++) begin
            drive_edge();
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 6) == 0) data_req[c] = ~data_req[c];
                if (!data_req[c]) data[c*N +: N] = N'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        drive_edge();
        data_req  = '0;
        out_ready = 1'b1;
        repeat (12) @(posedge clkb);

        // Mid-operation reset with three words queued and ch1 holding its ack
        drive_edge();
        out_ready = 1'b0;
        send(0, 8'h61, 6, 5);
        send(0, 8'h62, 6, 5);
        drive_edge();
        data[15:8]  = 8'h63;
        data_req[1] = 1'b1;
        repeat (6) @(posedge clkb);
        @(negedge clkb);
        check("mr_count_before", 32'(fc_m[1]), 32'h3);
        check("mr_ack_before", 32'(ack_m[1][1]), 32'h1);
        drive_edge();
        rst = 1'b1;
        drive_edge();
        rst = 1'b0;
        @(negedge clkb);
        check("mr_valid", 32'(ov_m[1]), 32'h0);
        check("mr_count", 32'(fc_m[1]), 32'h0);
        check("mr_ack", 32'(ack_m[1]), 32'h0);
        repeat (3) @(posedge clkb);
        @(negedge clkb);
        check("mr_not_yet", 32'(fc_m[1]), 32'h0);
        @(posedge clkb);
        @(negedge clkb);
        check("mr_reaccept_count", 32'(fc_m[1]), 32'h1);
        check("mr_reaccept_ack", 32'(ack_m[1][1]), 32'h1);
        drive_edge();
        data_req  = '0;
        out_ready = 1'b1;
        repeat (10) @(posedge clkb);
        @(negedge clkb);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
